panel_input_conditioner: RTL and testbench

Parametrised, multi-channel front-end conditioner for operator panel buttons and switches, sitting between the board pins and `core_top` in the SoC top level. Each channel is synchronised, then debounced with a counter, and presented either as a stable level or as a single-cycle pulse on press. Pulse channels can optionally auto-repeat while held. It replaces the per-signal fixed-function pulse and level conditioners with one block configured by masks.

---
 rtl/panel_io_pkg.sv | 21 ++
 rtl/panel_input_conditioner_if.sv | 24 ++
 rtl/debounce_channel.sv | 133 +++++++++++++
 rtl/panel_input_conditioner.sv | 56 +++++
 tb/tb_panel_input_conditioner.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/panel_io_pkg.sv
// Shared types and defaults for the operator panel input conditioner.
// The default constants are also referenced by the SoC top level.
package panel_io_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      PERIOD = 2'd2
   } repeat_state_t;

   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
   localparam int DEFAULT_REPEAT_DELAY    = 1000;
   localparam int DEFAULT_REPEAT_PERIOD   = 200;

   // Width of a counter that must hold 0..max_value (at least one bit).
   function automatic int cnt_width(input int max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/panel_input_conditioner_if.sv
// Pin-side and core-side signal bundle of the panel input conditioner.
// The conditioner uses the slave modport; the source of raw_in uses master.
interface panel_input_conditioner_if #(
   parameter int CHANNELS = 11
);
   logic [CHANNELS-1:0] raw_in;
   logic [CHANNELS-1:0] level_out;
   logic [CHANNELS-1:0] pulse_out;
   logic                level_changed;

   modport master (
      output raw_in,
      input  level_out,
      input  pulse_out,
      input  level_changed
   );

   modport slave (
      input  raw_in,
      output level_out,
      output pulse_out,
      output level_changed
   );
endinterface

// File: rtl/debounce_channel.sv
// One panel input: synchroniser, counter debounce, press edge detect and
// optional auto-repeat state machine.
module debounce_channel
   import panel_io_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit PULSE_EN        = 1'b0,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
   parameter bit INIT_LEVEL      = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse,
   output logic toggle
);

   generate
      if (SYNC_STAGES < 2)     $error("SYNC_STAGES must be at least 2");
      if (DEBOUNCE_CYCLES < 1) $error("DEBOUNCE_CYCLES must be at least 1");
      if (REPEAT_DELAY < 1)    $error("REPEAT_DELAY must be at least 1");
      if (REPEAT_PERIOD < 1)   $error("REPEAT_PERIOD must be at least 1");
   endgenerate

   localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam int REP_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
   localparam int REP_W   = cnt_width(REP_MAX);

   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

   // Preset to the init level so no edge is seen when reset releases.
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_reg <= {SYNC_STAGES{INIT_LEVEL}};
      else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
   end

   assign s = sync_reg[SYNC_STAGES-1];

   logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
   logic            level_reg;
   logic            toggle_next;
   logic            rise, fall;

   always_comb begin
      db_cnt_next = '0;
      toggle_next = 1'b0;
      if (s != level_reg) begin
         if (db_cnt_reg == DB_LAST) toggle_next = 1'b1;
         else                       db_cnt_next = db_cnt_reg + 1'b1;
      end
   end

   assign rise = toggle_next & ~level_reg;
   assign fall = toggle_next & level_reg;

   repeat_state_t    rep_state_reg, rep_state_next;
   logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
   logic             rep_due;

   // A release always wins over a repeat pulse falling due on the same edge.
   always_comb begin
      rep_state_next = rep_state_reg;
      rep_cnt_next   = rep_cnt_reg;
      rep_due        = 1'b0;
      case (rep_state_reg)
         IDLE: begin
            rep_cnt_next = '0;
            if (rise && PULSE_EN && REPEAT_EN) rep_state_next = DELAY;
         end
         DELAY: begin
            if (fall) begin
               rep_state_next = IDLE;
               rep_cnt_next   = '0;
            end else if (rep_cnt_reg == DELAY_LAST) begin
               rep_due        = 1'b1;
               rep_state_next = PERIOD;
               rep_cnt_next   = '0;
            end else begin
               rep_cnt_next = rep_cnt_reg + 1'b1;
            end
         end
         PERIOD: begin
            if (fall) begin
               rep_state_next = IDLE;
               rep_cnt_next   = '0;
            end else if (rep_cnt_reg == PERIOD_LAST) begin
               rep_due      = 1'b1;
               rep_cnt_next = '0;
            end else begin
               rep_cnt_next = rep_cnt_reg + 1'b1;
            end
         end
         default: begin
            rep_state_next = IDLE;
            rep_cnt_next   = '0;
         end
      endcase
   end

   logic pulse_reg, pulse_next;

   assign pulse_next = PULSE_EN & (rise | rep_due);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_cnt_reg    <= '0;
         level_reg     <= INIT_LEVEL;
         pulse_reg     <= 1'b0;
         rep_state_reg <= IDLE;
         rep_cnt_reg   <= '0;
      end else begin
         db_cnt_reg    <= db_cnt_next;
         level_reg     <= level_reg ^ toggle_next;
         pulse_reg     <= pulse_next;
         rep_state_reg <= rep_state_next;
         rep_cnt_reg   <= rep_cnt_next;
      end
   end

   assign level  = level_reg;
   assign pulse  = pulse_reg;
   assign toggle = toggle_next;

endmodule

// File: rtl/panel_input_conditioner.sv
// Multi-channel panel button/switch conditioner: one debounce_channel per
// input, configured by masks, plus a shared strobe for level-channel changes.
module panel_input_conditioner
   import panel_io_pkg::*;
#(
   parameter int                  CHANNELS        = 11,
   parameter int                  SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [CHANNELS-1:0] PULSE_MASK      = '0,
   parameter logic [CHANNELS-1:0] REPEAT_MASK     = '0,
   parameter int                  REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int                  REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
   parameter logic [CHANNELS-1:0] INIT_LEVEL      = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   panel_input_conditioner_if.slave  bus
);

   logic [CHANNELS-1:0] level_w;
   logic [CHANNELS-1:0] pulse_w;
   logic [CHANNELS-1:0] toggle_w;
   logic                level_changed_reg;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_EN        (PULSE_MASK[gi]),
            .REPEAT_EN       (PULSE_MASK[gi] & REPEAT_MASK[gi]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .INIT_LEVEL      (INIT_LEVEL[gi])
         ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.raw_in[gi]),
            .level  (level_w[gi]),
            .pulse  (pulse_w[gi]),
            .toggle (toggle_w[gi])
         );
      end
   endgenerate

   // Registered alongside level_out so the strobe lines up with the new level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) level_changed_reg <= 1'b0;
      else       level_changed_reg <= |(toggle_w & ~PULSE_MASK);
   end

   assign bus.level_out     = level_w;
   assign bus.pulse_out     = pulse_w;
   assign bus.level_changed = level_changed_reg;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed bench for panel_input_conditioner: 4 channels, two pulse channels
// (one auto-repeating), two level channels with mixed init levels.
module tb_panel_input_conditioner;

   localparam int         CH  = 4;
   localparam logic [3:0] INI = 4'b0100;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   panel_input_conditioner_if #(.CHANNELS(CH)) bus ();

   panel_input_conditioner #(
      .CHANNELS        (CH),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8),
      .PULSE_MASK      (4'b0011),
      .REPEAT_MASK     (4'b0001),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (5),
      .INIT_LEVEL      (INI)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
         $display("ok   %s = %0d", tag, obs);
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Per-edge history; index 0 holds the level before the first recorded edge.
   logic [3:0] lvl_h [0:127];
   logic [3:0] pls_h [0:127];
   logic       lc_h  [0:127];
   int         hist_len;

   task automatic clear_hist();
      hist_len = 0;
      lvl_h[0] = bus.level_out;
      pls_h[0] = 4'b0000;
      lc_h[0]  = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         hist_len++;
         lvl_h[hist_len] = bus.level_out;
         pls_h[hist_len] = bus.pulse_out;
         lc_h[hist_len]  = bus.level_changed;
      end
   endtask

   function automatic int first_edge(input int ch, input logic v);
      for (int e = 1; e <= hist_len; e++)
         if (lvl_h[e][ch] == v && lvl_h[e-1][ch] != v) return e;
      return -1;
   endfunction

   function automatic int count_pls(input int ch);
      int c = 0;
      for (int e = 1; e <= hist_len; e++) if (pls_h[e][ch]) c++;
      return c;
   endfunction

   function automatic int count_pls_all();
      int c = 0;
      for (int e = 1; e <= hist_len; e++) c += (pls_h[e] != 4'b0000) ? 1 : 0;
      return c;
   endfunction

   function automatic int nth_pls(input int ch, input int k);
      int c = 0;
      for (int e = 1; e <= hist_len; e++)
         if (pls_h[e][ch]) begin
            if (c == k) return e;
            c++;
         end
      return -1;
   endfunction

   function automatic int count_lc();
      int c = 0;
      for (int e = 1; e <= hist_len; e++) if (lc_h[e]) c++;
      return c;
   endfunction

   function automatic int first_lc();
      for (int e = 1; e <= hist_len; e++) if (lc_h[e]) return e;
      return -1;
   endfunction

   int rep_edges [7] = '{10, 30, 35, 40, 45, 50, 55};

   initial begin
      reset      = 1'b1;
      bus.raw_in = INI;
      repeat (3) @(posedge clk);
      #1;
      check("reset_level", int'(bus.level_out), int'(INI));
      check("reset_pulse", int'(bus.pulse_out), 0);
      check("reset_lc", int'(bus.level_changed), 0);

      @(negedge clk);
      reset = 1'b0;
      clear_hist();
      run(50);
      check("idle_pulses", count_pls_all(), 0);
      check("idle_lc", count_lc(), 0);
      check("idle_level", int'(lvl_h[50]), int'(INI));

      // Button press and release on channel 1 (no repeat)
      clear_hist();
      bus.raw_in = 4'b0110;
      run(20);
      check("ch1_rise_edge", first_edge(1, 1'b1), 10);
      check("ch1_press_count", count_pls(1), 1);
      check("ch1_press_edge", nth_pls(1, 0), 10);
      check("ch1_press_lc", count_lc(), 0);
      clear_hist();
      bus.raw_in = 4'b0100;
      run(20);
      check("ch1_fall_edge", first_edge(1, 1'b0), 10);
      check("ch1_release_pulses", count_pls(1), 0);

      // Bounce: 7 high, 1 low, 7 high, low
      clear_hist();
      bus.raw_in = 4'b0110;
      run(7);
      bus.raw_in = 4'b0100;
      run(1);
      bus.raw_in = 4'b0110;
      run(7);
      bus.raw_in = 4'b0100;
      run(20);
      check("bounce_rise", first_edge(1, 1'b1), -1);
      check("bounce_pulses", count_pls(1), 0);

      // Auto-repeat on channel 0; release lands on the edge a repeat is due
      clear_hist();
      bus.raw_in = 4'b0101;
      run(50);
      bus.raw_in = 4'b0100;
      run(50);
      check("rep_count", count_pls(0), 7);
      for (int k = 0; k < 7; k++)
         check($sformatf("rep_edge%0d", k), nth_pls(0, k), rep_edges[k]);
      check("rep_fall_edge", first_edge(0, 1'b0), 60);

      // Two level channels toggle together
      clear_hist();
      bus.raw_in = 4'b1000;
      run(20);
      check("lvl2_fall_edge", first_edge(2, 1'b0), 10);
      check("lvl3_rise_edge", first_edge(3, 1'b1), 10);
      check("lvl_lc_count", count_lc(), 1);
      check("lvl_lc_edge", first_lc(), 10);
      check("lvl_pulses", count_pls_all(), 0);
      clear_hist();
      bus.raw_in = 4'b0100;
      run(20);
      check("lvl_back_lc_count", count_lc(), 1);
      check("lvl_back_lc_edge", first_lc(), 10);
      check("lvl_back_level", int'(lvl_h[20]), int'(INI));

      // Asynchronous reset mid-repeat, pin still held
      clear_hist();
      bus.raw_in = 4'b0101;
      run(25);
      check("pre_reset_pulses", count_pls(0), 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_level", int'(bus.level_out), int'(INI));
      check("async_reset_pulse", int'(bus.pulse_out), 0);
      check("async_reset_lc", int'(bus.level_changed), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_hist();
      run(15);
      check("post_reset_press_edge", nth_pls(0, 0), 10);
      check("post_reset_press_count", count_pls(0), 1);
      check("post_reset_rise_edge", first_edge(0, 1'b1), 10);
      bus.raw_in = 4'b0100;
      run(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
